// File: rtl/ef_tmr32_fault_filter_if.sv
// Signal bundle between the timer/PWM fault logic and the fault pin filter.
// The slave side is the filter itself; the master side is whatever configures it and consumes its outputs.
interface ef_tmr32_fault_filter_if #(
  parameter int CW = 8
);
  logic          en;
  logic          fault_in;
  logic          fault_pol;
  logic [CW-1:0] flt_len;
  logic          force_fault;
  logic          cnt_clr;
  logic          pwm_fault;
  logic          fault_rise;
  logic          fault_act;
  logic [7:0]    fault_cnt;

  modport master (
    output en, fault_in, fault_pol, flt_len, force_fault, cnt_clr,
    input  pwm_fault, fault_rise, fault_act, fault_cnt
  );

  modport slave (
    input  en, fault_in, fault_pol, flt_len, force_fault, cnt_clr,
    output pwm_fault, fault_rise, fault_act, fault_cnt
  );
endinterface

// File: rtl/ef_tmr32_fault_filter.sv
// Fault pin qualifier: synchronizes the external fault pin, then requires L
// consecutive matching samples before asserting or releasing pwm_fault.
module ef_tmr32_fault_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 8
) (
  input logic                    clk,
  input logic                    rst,
  ef_tmr32_fault_filter_if.slave bus
);

  localparam int            FW         = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FLUSH_DONE = FW'(SYNC_STAGES);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);
  localparam logic [CW-1:0] LEN_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    FAULT,
    REL
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          flush_q;
  logic                   sync_out;
  logic                   act;
  logic [CW-1:0]          len_eff;
  logic                   len_one;
  logic                   cnt_hit;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic [7:0]             fault_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.fault_in};
    end
  end

  // The chain holds reset values until SYNC_STAGES real samples have shifted
  // through; act stays masked until then so those values can never qualify.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_q <= '0;
    end else if (flush_q != FLUSH_DONE) begin
      flush_q <= flush_q + FLUSH_ONE;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign act      = (flush_q == FLUSH_DONE) && (bus.fault_pol ? sync_out : ~sync_out);
  assign len_eff  = (bus.flt_len == '0) ? LEN_ONE : bus.flt_len;
  assign len_one  = (len_eff == LEN_ONE);
  // cnt+1 >= L written without widening; also exits at once if L shrinks below cnt.
  assign cnt_hit  = (cnt_q >= (len_eff - LEN_ONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.force_fault) begin
      state_d = FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (act) begin
            if (len_one) begin
              state_d = FAULT;
              cnt_d   = '0;
            end else begin
              state_d = QUAL;
              cnt_d   = LEN_ONE;
            end
          end
        end
        QUAL: begin
          if (!act) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_hit) begin
            state_d = FAULT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_ONE;
          end
        end
        FAULT: begin
          if (!act) begin
            if (len_one) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = REL;
              cnt_d   = LEN_ONE;
            end
          end
        end
        REL: begin
          if (act) begin
            state_d = FAULT;
            cnt_d   = '0;
          end else if (cnt_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + LEN_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    rise_d = (state_d == FAULT) && ((state_q == IDLE) || (state_q == QUAL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  // Counts each fault_rise pulse while it is high; a clear in the same cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      fault_cnt_q <= '0;
    end else if (rise_q && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign bus.pwm_fault  = (state_q == FAULT) || (state_q == REL);
  assign bus.fault_rise = rise_q;
  assign bus.fault_act  = act;
  assign bus.fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_ef_tmr32_fault_filter.sv
// Bench for the fault pin qualifier: vector table, directed corner cases and
// random pin activity compared against a level/run-length reference model.
module tb_ef_tmr32_fault_filter;

  localparam int SYNC = 2;

  typedef struct {
    bit en;
    bit fin;
    bit pol;
    int len;
    bit frc;
    bit clr;
    bit e_pwm;
    bit e_rise;
    bit e_act;
    int e_cnt;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model: qualified level plus length of the current opposing run.
  int   edge_n;
  bit   pin_q[$];
  bit   m_level;
  int   m_run;
  int   m_cnt;
  bit   m_rise;

  vec_t tbl[20];

  ef_tmr32_fault_filter_if #(.CW(8)) bus ();

  ef_tmr32_fault_filter #(
    .SYNC_STAGES(SYNC),
    .CW         (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    pin_q.delete();
    m_level = 0;
    m_run   = 0;
    m_cnt   = 0;
    m_rise  = 0;
  endtask

  // Advances the model by one clock edge using the inputs currently applied,
  // then lets the DUT take that edge and returns on the following falling edge.
  task automatic applyStimulus();
    bit s;
    bit a;
    bit prev;
    int len;
    edge_n++;
    pin_q.push_back(bus.fault_in);
    if (pin_q.size() > SYNC + 1) void'(pin_q.pop_front());
    a = 0;
    if (edge_n > SYNC) begin
      s = pin_q[0];
      a = bus.fault_pol ? s : !s;
    end
    len = (bus.flt_len == 0) ? 1 : int'(bus.flt_len);
    if (bus.cnt_clr) m_cnt = 0;
    else if (m_rise && m_cnt < 255) m_cnt++;
    prev = m_level;
    if (!bus.en) begin
      m_level = 0;
      m_run   = 0;
    end else if (bus.force_fault) begin
      m_level = 1;
      m_run   = 0;
    end else begin
      if (a != m_level) m_run++;
      else m_run = 0;
      if (m_run >= len) begin
        m_level = !m_level;
        m_run   = 0;
      end
    end
    m_rise = bus.en && !prev && m_level;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    bit s;
    bit e_act;
    e_act = 0;
    if (edge_n >= SYNC) begin
      s = pin_q[pin_q.size() - SYNC];
      e_act = bus.fault_pol ? s : !s;
    end
    checkValue($sformatf("%s.pwm_fault", tag), 32'(bus.pwm_fault), 32'(m_level));
    checkValue($sformatf("%s.fault_rise", tag), 32'(bus.fault_rise), 32'(m_rise));
    checkValue($sformatf("%s.fault_act", tag), 32'(bus.fault_act), 32'(e_act));
    checkValue($sformatf("%s.fault_cnt", tag), 32'(bus.fault_cnt), 32'(m_cnt));
  endtask

  // Called on a falling edge; checks outputs clear before any clock arrives.
  task automatic apply_reset();
    rst = 1;
    #2;
    checkValue("rst.pwm_fault", 32'(bus.pwm_fault), 0);
    checkValue("rst.fault_rise", 32'(bus.fault_rise), 0);
    checkValue("rst.fault_act", 32'(bus.fault_act), 0);
    checkValue("rst.fault_cnt", 32'(bus.fault_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    int k;
    clk             = 0;
    rst             = 1;
    checks          = 0;
    errors          = 0;
    bus.en          = 1;
    bus.fault_in    = 0;
    bus.fault_pol   = 1;
    bus.flt_len     = 8'd3;
    bus.force_fault = 0;
    bus.cnt_clr     = 0;
    model_reset();

    //            en fin pol len frc clr  pwm rise act cnt
    tbl[0]  = '{1, 1, 1, 3, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 3, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 1, 1, 3, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 1, 3, 0, 0, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 1, 3, 0, 0, 1, 1, 1, 0};
    tbl[5]  = '{1, 1, 1, 3, 0, 0, 1, 0, 1, 1};
    tbl[6]  = '{1, 0, 1, 3, 0, 0, 1, 0, 1, 1};
    tbl[7]  = '{1, 0, 1, 3, 0, 0, 1, 0, 0, 1};
    tbl[8]  = '{1, 0, 1, 3, 0, 0, 1, 0, 0, 1};
    tbl[9]  = '{1, 0, 1, 3, 0, 0, 1, 0, 0, 1};
    tbl[10] = '{1, 0, 1, 3, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{1, 1, 1, 4, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{1, 1, 1, 4, 0, 0, 0, 0, 1, 1};
    tbl[13] = '{1, 1, 1, 4, 0, 0, 0, 0, 1, 1};
    tbl[14] = '{1, 0, 1, 4, 0, 0, 0, 0, 1, 1};
    tbl[15] = '{1, 0, 1, 4, 0, 0, 0, 0, 0, 1};
    tbl[16] = '{1, 0, 1, 4, 0, 0, 0, 0, 0, 1};
    tbl[17] = '{1, 0, 1, 4, 0, 0, 0, 0, 0, 1};
    tbl[18] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    tbl[19] = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 2};

    apply_reset();
    repeat (4) begin
      applyStimulus();
      checkOutput("settle");
    end

    for (int i = 0; i < 20; i++) begin
      bus.en          = tbl[i].en;
      bus.fault_in    = tbl[i].fin;
      bus.fault_pol   = tbl[i].pol;
      bus.flt_len     = 8'(tbl[i].len);
      bus.force_fault = tbl[i].frc;
      bus.cnt_clr     = tbl[i].clr;
      applyStimulus();
      checkOutput($sformatf("tbl%0d.model", i));
      checkValue($sformatf("tbl%0d.pwm_fault", i), 32'(bus.pwm_fault), 32'(tbl[i].e_pwm));
      checkValue($sformatf("tbl%0d.fault_rise", i), 32'(bus.fault_rise), 32'(tbl[i].e_rise));
      checkValue($sformatf("tbl%0d.fault_act", i), 32'(bus.fault_act), 32'(tbl[i].e_act));
      checkValue($sformatf("tbl%0d.fault_cnt", i), 32'(bus.fault_cnt), 32'(tbl[i].e_cnt));
    end

    // One-cycle software force from IDLE with L=2, then en=0 overriding force.
    bus.fault_in = 0; bus.fault_pol = 1; bus.flt_len = 8'd2;
    bus.force_fault = 1;
    applyStimulus(); checkOutput("force1");
    checkValue("force1.pwm_fault", 32'(bus.pwm_fault), 1);
    checkValue("force1.fault_rise", 32'(bus.fault_rise), 1);
    bus.force_fault = 0;
    applyStimulus(); checkOutput("force2");
    checkValue("force2.pwm_fault", 32'(bus.pwm_fault), 1);
    checkValue("force2.fault_cnt", 32'(bus.fault_cnt), 3);
    applyStimulus(); checkOutput("force3");
    checkValue("force3.pwm_fault", 32'(bus.pwm_fault), 0);
    bus.force_fault = 1;
    applyStimulus(); checkOutput("force4");
    bus.en = 0;
    applyStimulus(); checkOutput("en_off");
    checkValue("en_off.pwm_fault", 32'(bus.pwm_fault), 0);
    checkValue("en_off.fault_rise", 32'(bus.fault_rise), 0);
    bus.en = 1; bus.force_fault = 0;
    applyStimulus(); checkOutput("en_on");

    // In FAULT with L=4: short inactive dip must not release or re-pulse.
    bus.flt_len = 8'd4; bus.fault_in = 1;
    repeat (8) begin applyStimulus(); checkOutput("dip_enter"); end
    checkValue("dip_enter.pwm_fault", 32'(bus.pwm_fault), 1);
    for (int i = 0; i < 6; i++) begin
      bus.fault_in = (i >= 2);
      applyStimulus(); checkOutput("dip");
      checkValue($sformatf("dip%0d.pwm_fault", i), 32'(bus.pwm_fault), 1);
      checkValue($sformatf("dip%0d.fault_rise", i), 32'(bus.fault_rise), 0);
    end
    bus.fault_in = 0;
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      applyStimulus(); checkOutput("release");
      if (!bus.pwm_fault) k = i;
    end
    checkValue("release_latency", 32'(k), 32'(SYNC + 4));

    // Async reset while in FAULT, then inverted-polarity pin held through release.
    bus.force_fault = 1;
    applyStimulus(); checkOutput("pre_rst");
    checkValue("pre_rst.pwm_fault", 32'(bus.pwm_fault), 1);
    bus.force_fault = 0; bus.fault_pol = 0; bus.fault_in = 1; bus.flt_len = 8'd1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(); checkOutput("flush");
      checkValue($sformatf("flush%0d.pwm_fault", i), 32'(bus.pwm_fault), 0);
      checkValue($sformatf("flush%0d.fault_act", i), 32'(bus.fault_act), 0);
    end

    // Saturation of the fault counter and clear winning over an increment.
    bus.fault_pol = 1; bus.fault_in = 0; bus.flt_len = 8'd1;
    bus.cnt_clr = 1;
    applyStimulus(); checkOutput("clr");
    bus.cnt_clr = 0;
    for (int i = 0; i < 256; i++) begin
      bus.force_fault = 1;
      applyStimulus(); checkOutput("sat");
      bus.force_fault = 0;
      applyStimulus(); checkOutput("sat");
    end
    checkValue("sat.fault_cnt", 32'(bus.fault_cnt), 255);
    bus.force_fault = 1;
    applyStimulus(); checkOutput("rise257");
    checkValue("rise257.fault_rise", 32'(bus.fault_rise), 1);
    checkValue("rise257.fault_cnt", 32'(bus.fault_cnt), 255);
    bus.force_fault = 0; bus.cnt_clr = 1;
    applyStimulus(); checkOutput("clr257");
    checkValue("clr257.fault_cnt", 32'(bus.fault_cnt), 0);
    bus.cnt_clr = 0;
    applyStimulus(); checkOutput("after_clr");
    checkValue("after_clr.fault_cnt", 32'(bus.fault_cnt), 0);

    // Random pin activity with live changes to length, polarity and controls.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) bus.fault_in = ~bus.fault_in;
      if ($urandom_range(0, 99) < 1) bus.fault_pol = ~bus.fault_pol;
      if ($urandom_range(0, 99) < 5) bus.flt_len = 8'($urandom_range(0, 6));
      bus.force_fault = ($urandom_range(0, 99) < 3);
      bus.en          = ($urandom_range(0, 99) < 97);
      bus.cnt_clr     = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 999) < 2) apply_reset();
      applyStimulus();
      checkOutput("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ef_tmr32_fault_filter.md
EF_TMR32_FAULT_FILTER -- requirements
Module: ef_tmr32_fault_filter

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2 (min 2), meaning the synchronizer flip-flop count on fault_in.
REQ-002 The block SHALL have parameter CW, default 8, meaning the width of the qualification length and counter.
REQ-003 Port clk, input, 1, the single clock; all state SHALL be clocked on the rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port en, input, 1, filter enable.
REQ-006 Port fault_in, input, 1, asynchronous external fault pin.
REQ-007 Port fault_pol, input, 1, fault polarity: 1 means pin-high is a fault, 0 means pin-low is a fault.
REQ-008 Port flt_len, input, CW, number of consecutive samples needed to assert or release; values 0 and 1 both mean 1.
REQ-009 Port force_fault, input, 1, software fault that bypasses the filter.
REQ-010 Port cnt_clr, input, 1, synchronous clear of fault_cnt.
REQ-011 Port pwm_fault, output, 1, qualified fault level; drives the timer/PWM pwm_fault input.
REQ-012 Port fault_rise, output, 1, one-cycle pulse on each new qualified fault.
REQ-013 Port fault_act, output, 1, synchronized, polarity-corrected, unfiltered pin state.
REQ-014 Port fault_cnt, output, 8, saturating count of qualified faults.

Function
REQ-015 fault_in SHALL pass through SYNC_STAGES flip-flops; act = fault_pol ? sync_out : ~sync_out.
REQ-016 act SHALL be masked to 0 for the first SYNC_STAGES clocks after reset release (flush counter), so a reset-valued chain can never qualify.
REQ-017 fault_act SHALL equal masked act.
REQ-018 The FSM SHALL have states IDLE, QUAL, FAULT, REL, with counter cnt[CW-1:0]; L = max(flt_len,1), sampled live each cycle.
REQ-019 IDLE on act: go to FAULT if L==1, else go to QUAL with cnt=1.
REQ-020 QUAL on ~act: go to IDLE with cnt=0; on act: go to FAULT if cnt+1>=L, else cnt++.
REQ-021 FAULT on ~act: go to IDLE if L==1, else go to REL with cnt=1; on act: stay in FAULT.
REQ-022 REL on act: go to FAULT with cnt=0; on ~act: go to IDLE if cnt+1>=L, else cnt++.
REQ-023 The >= compare SHALL guarantee exit when flt_len is lowered mid-count; cnt SHALL never wrap.
REQ-024 pwm_fault SHALL be 1 exactly when state is FAULT or REL (decoded from registered state, no combinational path from fault_in).
REQ-025 Pin-to-pwm_fault assertion latency SHALL be SYNC_STAGES+L clock edges; release latency SHALL be the same.
REQ-026 force_fault=1 SHALL move any state to FAULT at the next edge with cnt=0, and hold it there while high; on force deassert, normal REQ-021/022 rules SHALL resume.
REQ-027 en=0 SHALL force state IDLE, cnt=0, pwm_fault=0, fault_rise=0 at the next edge, with priority over force_fault; the synchronizer SHALL keep running.
REQ-028 fault_rise SHALL pulse for one cycle in the first cycle that state is FAULT after being IDLE or QUAL; REL-to-FAULT SHALL NOT pulse.
REQ-029 fault_cnt SHALL increment on fault_rise and saturate at 255.
REQ-030 cnt_clr SHALL set fault_cnt to 0 and win over a simultaneous increment.

Reset
REQ-031 rst SHALL asynchronously clear the synchronizer chain, flush counter, state (IDLE), cnt, and fault_cnt.
REQ-032 During reset: pwm_fault=0, fault_rise=0, fault_act=0, fault_cnt=0.
REQ-033 rst mid-FAULT SHALL drop pwm_fault immediately, without waiting for a clock.

Verification
REQ-034 pol=1, L=3, en=1, fault_in rises before edge 0 -> pwm_fault=1 after edge 4; fault_rise high for 1 cycle; fault_cnt=1.
REQ-035 pol=1, L=4, a 3-cycle fault_in glitch -> pwm_fault stays 0; fault_cnt stays 0.
REQ-036 In FAULT with L=4: pin inactive 2 cycles, then active -> stays FAULT, no fault_rise; then inactive 6 cycles -> IDLE after 2+4 edges.
REQ-037 pol=0, fault_in=1 held through reset release, L=1 -> pwm_fault never asserts (flush mask).
REQ-038 force_fault pulse of 1 cycle in IDLE with pin inactive, L=2 -> FAULT for 1 cycle, REL for 1 cycle, then IDLE; fault_cnt=1; en=0 in FAULT -> pwm_fault=0 next edge.
REQ-039 256 qualified faults with cnt_clr asserted on the 257th rise -> fault_cnt holds 255, then reads 0.
